// File: rtl/load_store_unit.sv
// Byte-serial load/store execution unit: one access in flight, result broadcast for
// exactly one cycle on the memory result bus.
module load_store_unit #(
    parameter int         ADDR_WIDTH = 32,
    parameter logic [4:0] IDLE_OP    = 5'b11111
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic [4:0]            memory_op,
    input  logic [31:0]           memory_value1,
    input  logic [31:0]           memory_value2,
    input  logic [31:0]           memory_imm,
    input  logic [2:0]            memory_des,
    output logic                  lsu_ready,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic [7:0]            mem_dout,
    output logic                  mem_wr,
    input  logic [7:0]            mem_din,
    output logic [31:0]           result_data,
    output logic [2:0]            result_des
);

    localparam logic [4:0] OP_LB  = 5'b10010;
    localparam logic [4:0] OP_LH  = 5'b10011;
    localparam logic [4:0] OP_LW  = 5'b10100;
    localparam logic [4:0] OP_LBU = 5'b10101;
    localparam logic [4:0] OP_LHU = 5'b10110;
    localparam logic [4:0] OP_SB  = 5'b10111;
    localparam logic [4:0] OP_SH  = 5'b11000;
    localparam logic [4:0] OP_SW  = 5'b11001;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t                r_state;
    logic [4:0]            r_op;
    logic [2:0]            r_des;
    logic [2:0]            r_len;
    logic [2:0]            r_cnt;
    logic [31:0]           r_data;
    logic                  r_clr;
    logic                  r_lsu_ready;
    logic [ADDR_WIDTH-1:0] r_mem_a;
    logic [7:0]            r_mem_dout;
    logic                  r_mem_wr;
    logic [31:0]           r_result_data;
    logic [2:0]            r_result_des;

    logic                  w_valid;
    logic                  w_store;
    logic [2:0]            w_len;
    logic [31:0]           w_ea;
    logic [31:0]           w_rdata;
    logic [31:0]           w_load_val;

    always_comb begin
        w_valid = 1'b1;
        w_store = 1'b0;
        w_len   = 3'd1;
        case (memory_op)
            OP_LB, OP_LBU: w_len = 3'd1;
            OP_LH, OP_LHU: w_len = 3'd2;
            OP_LW:         w_len = 3'd4;
            OP_SB: begin w_len = 3'd1; w_store = 1'b1; end
            OP_SH: begin w_len = 3'd2; w_store = 1'b1; end
            OP_SW: begin w_len = 3'd4; w_store = 1'b1; end
            default:       w_valid = 1'b0;
        endcase
        if (memory_op == IDLE_OP) begin
            w_valid = 1'b0;
        end
    end

    assign w_ea = memory_value1 + memory_imm;

    // r_cnt is the index of the byte arriving on mem_din this cycle
    for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
        assign w_rdata[gi*8 +: 8] = (r_cnt == 3'(gi)) ? mem_din : r_data[gi*8 +: 8];
    end

    always_comb begin
        case (r_op)
            OP_LB:   w_load_val = {{24{w_rdata[7]}}, w_rdata[7:0]};
            OP_LBU:  w_load_val = {24'h000000, w_rdata[7:0]};
            OP_LH:   w_load_val = {{16{w_rdata[15]}}, w_rdata[15:0]};
            OP_LHU:  w_load_val = {16'h0000, w_rdata[15:0]};
            default: w_load_val = w_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_op          <= IDLE_OP;
            r_des         <= 3'd0;
            r_len         <= 3'd0;
            r_cnt         <= 3'd0;
            r_data        <= 32'd0;
            r_clr         <= 1'b0;
            r_lsu_ready   <= 1'b1;
            r_mem_a       <= '0;
            r_mem_dout    <= 8'd0;
            r_mem_wr      <= 1'b0;
            r_result_data <= 32'd0;
            r_result_des  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_lsu_ready && !clear && w_valid) begin
                        r_op        <= memory_op;
                        r_des       <= memory_des;
                        r_len       <= w_len;
                        r_clr       <= 1'b0;
                        r_lsu_ready <= 1'b0;
                        r_mem_a     <= w_ea[ADDR_WIDTH-1:0];
                        if (w_store) begin
                            r_state    <= S_WRITE;
                            r_mem_wr   <= 1'b1;
                            r_mem_dout <= memory_value2[7:0];
                            r_data     <= {8'h00, memory_value2[31:8]};
                            r_cnt      <= 3'd1;
                        end else begin
                            r_state  <= S_READ;
                            r_mem_wr <= 1'b0;
                            r_data   <= 32'd0;
                            r_cnt    <= 3'd0;
                        end
                    end
                end
                S_READ: begin
                    if (clear) begin
                        r_state     <= S_IDLE;
                        r_lsu_ready <= 1'b1;
                    end else if (r_cnt + 3'd1 == r_len) begin
                        r_state       <= S_DONE;
                        r_result_data <= w_load_val;
                        r_result_des  <= r_des;
                    end else begin
                        r_data  <= w_rdata;
                        r_mem_a <= r_mem_a + ADDR_WIDTH'(1);
                        r_cnt   <= r_cnt + 3'd1;
                    end
                end
                S_WRITE: begin
                    // A flush never tears a store; it only hides the completion broadcast
                    if (r_cnt == r_len) begin
                        r_state       <= S_DONE;
                        r_mem_wr      <= 1'b0;
                        r_result_data <= 32'd0;
                        r_result_des  <= (clear || r_clr) ? 3'd0 : r_des;
                    end else begin
                        r_mem_a    <= r_mem_a + ADDR_WIDTH'(1);
                        r_mem_dout <= r_data[7:0];
                        r_data     <= {8'h00, r_data[31:8]};
                        r_cnt      <= r_cnt + 3'd1;
                        r_clr      <= r_clr | clear;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_lsu_ready   <= 1'b1;
                    r_result_data <= 32'd0;
                    r_result_des  <= 3'd0;
                    r_clr         <= 1'b0;
                end
            endcase
        end
    end

    assign lsu_ready   = r_lsu_ready;
    assign mem_a       = r_mem_a;
    assign mem_dout    = r_mem_dout;
    assign mem_wr      = r_mem_wr;
    assign result_data = r_result_data;
    assign result_des  = r_result_des;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random ops checked
// against a byte-array reference memory and per-cycle expectations.
module tb_load_store_unit;

    localparam logic [4:0] LB = 5'b10010, LH = 5'b10011, LW = 5'b10100, LBU = 5'b10101;
    localparam logic [4:0] LHU = 5'b10110, SB = 5'b10111, SH = 5'b11000, SW = 5'b11001;
    localparam logic [4:0] IDLE = 5'b11111;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [4:0]  memory_op;
    logic [31:0] memory_value1, memory_value2, memory_imm;
    logic [2:0]  memory_des;
    logic        lsu_ready;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic [31:0] result_data;
    logic [2:0]  result_des;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  mem     [0:4095];
    logic [7:0]  ref_mem [0:4095];

    logic [31:0] t_a    [1:7];
    logic        t_wr   [1:7];
    logic [7:0]  t_dout [1:7];
    logic [2:0]  t_des  [1:7];
    logic [31:0] t_data [1:7];
    logic        t_rdy  [1:7];

    load_store_unit #(.ADDR_WIDTH(32), .IDLE_OP(5'b11111)) dut (
        .clk(clk), .rst(rst), .clear(clear), .memory_op(memory_op),
        .memory_value1(memory_value1), .memory_value2(memory_value2),
        .memory_imm(memory_imm), .memory_des(memory_des), .lsu_ready(lsu_ready),
        .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr), .mem_din(mem_din),
        .result_data(result_data), .result_des(result_des)
    );

    always #5 clk = ~clk;

    assign mem_din = mem[mem_a[11:0]];

    function automatic int op_len(input logic [4:0] op);
        case (op)
            LW, SW:            return 4;
            LH, LHU, SH:       return 2;
            default:           return 1;
        endcase
    endfunction

    function automatic bit op_store(input logic [4:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Issue one op, then record 7 cycles of outputs; memory writes land on posedge.
    task automatic drive_op(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                            input logic [31:0] imm, input logic [2:0] des,
                            input int clr_cyc, input bit intrude);
        int w = 0;
        @(negedge clk);
        while (!lsu_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!lsu_ready) begin
            n_checks++;
            $display("FAIL ready_timeout: lsu_ready=%0b required 1", lsu_ready);
        end
        memory_op = op; memory_value1 = v1; memory_value2 = v2; memory_imm = imm; memory_des = des;
        @(negedge clk);
        memory_op = IDLE;
        for (int c = 1; c <= 7; c++) begin
            t_a[c] = mem_a; t_wr[c] = mem_wr; t_dout[c] = mem_dout;
            t_des[c] = result_des; t_data[c] = result_data; t_rdy[c] = lsu_ready;
            clear = (c == clr_cyc);
            if (intrude && c == 1) begin
                memory_op = SB; memory_value1 = 32'h500; memory_imm = 0;
                memory_value2 = 32'hAA; memory_des = 3'd6;
            end else if (intrude && c == 6) begin
                memory_op = IDLE;
            end
            @(posedge clk);
            if (mem_wr) mem[mem_a[11:0]] = mem_dout;
            @(negedge clk);
        end
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (lsu_ready !== 1'b1) $display("FAIL rst_ready: got %0b required 1", lsu_ready); else n_pass++;
        n_checks++; if (mem_a !== 32'd0) $display("FAIL rst_mem_a: got %h required 0", mem_a); else n_pass++;
        n_checks++; if (mem_dout !== 8'd0) $display("FAIL rst_dout: got %h required 0", mem_dout); else n_pass++;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL rst_wr: got %0b required 0", mem_wr); else n_pass++;
        n_checks++; if (result_data !== 32'd0) $display("FAIL rst_data: got %h required 0", result_data); else n_pass++;
        n_checks++; if (result_des !== 3'd0) $display("FAIL rst_des: got %0d required 0", result_des); else n_pass++;
        rst = 1'b1;
    endtask

    task automatic test_lw();
        logic [31:0] exp_a [4] = '{32'h104, 32'h105, 32'h106, 32'h107};
        mem[12'h104] = 8'h78; mem[12'h105] = 8'h56; mem[12'h106] = 8'h34; mem[12'h107] = 8'h12;
        drive_op(LW, 32'h100, 32'h0, 32'd4, 3'd5, 0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            n_checks++; if (t_a[c] !== exp_a[c-1]) $display("FAIL lw_addr c%0d: got %h required %h", c, t_a[c], exp_a[c-1]); else n_pass++;
            n_checks++; if (t_des[c] !== 3'd0) $display("FAIL lw_early_des c%0d: got %0d required 0", c, t_des[c]); else n_pass++;
        end
        n_checks++; if (t_des[5] !== 3'd5) $display("FAIL lw_des: got %0d required 5", t_des[5]); else n_pass++;
        n_checks++; if (t_data[5] !== 32'h12345678) $display("FAIL lw_data: got %h required 12345678", t_data[5]); else n_pass++;
        n_checks++; if (t_rdy[5] !== 1'b0) $display("FAIL lw_rdy_done: got %0b required 0", t_rdy[5]); else n_pass++;
        n_checks++; if (t_des[6] !== 3'd0) $display("FAIL lw_des_after: got %0d required 0", t_des[6]); else n_pass++;
        n_checks++; if (t_rdy[6] !== 1'b1) $display("FAIL lw_rdy_after: got %0b required 1", t_rdy[6]); else n_pass++;
    endtask

    task automatic test_sign_ext();
        logic [4:0]  ops   [4] = '{LB, LBU, LH, LHU};
        logic [31:0] addrs [4] = '{32'h300, 32'h300, 32'h310, 32'h310};
        logic [31:0] exps  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8000, 32'h00008000};
        mem[12'h300] = 8'h80; mem[12'h310] = 8'h00; mem[12'h311] = 8'h80;
        for (int i = 0; i < 4; i++) begin
            int n = op_len(ops[i]);
            drive_op(ops[i], addrs[i], 32'h0, 32'h0, 3'd3, 0, 1'b0);
            n_checks++; if (t_des[n] !== 3'd0) $display("FAIL ext_early op%0d: got %0d required 0", i, t_des[n]); else n_pass++;
            n_checks++; if (t_des[n+1] !== 3'd3) $display("FAIL ext_des op%0d: got %0d required 3", i, t_des[n+1]); else n_pass++;
            n_checks++; if (t_data[n+1] !== exps[i]) $display("FAIL ext_data op%0d: got %h required %h", i, t_data[n+1], exps[i]); else n_pass++;
        end
    endtask

    task automatic test_store();
        mem[12'h200] = 8'h11; mem[12'h201] = 8'h11; mem[12'h202] = 8'h11;
        drive_op(SH, 32'h1F0, 32'hDEADBEEF, 32'h10, 3'd2, 0, 1'b0);
        n_checks++; if (t_wr[1] !== 1'b1 || t_a[1] !== 32'h200 || t_dout[1] !== 8'hEF)
            $display("FAIL sh_byte0: got wr=%0b a=%h d=%h required 1 200 ef", t_wr[1], t_a[1], t_dout[1]); else n_pass++;
        n_checks++; if (t_wr[2] !== 1'b1 || t_a[2] !== 32'h201 || t_dout[2] !== 8'hBE)
            $display("FAIL sh_byte1: got wr=%0b a=%h d=%h required 1 201 be", t_wr[2], t_a[2], t_dout[2]); else n_pass++;
        n_checks++; if (t_wr[3] !== 1'b0) $display("FAIL sh_wr_end: got %0b required 0", t_wr[3]); else n_pass++;
        n_checks++; if (t_des[3] !== 3'd2 || t_data[3] !== 32'd0)
            $display("FAIL sh_bcast: got des=%0d data=%h required 2 0", t_des[3], t_data[3]); else n_pass++;
        n_checks++; if (mem[12'h200] !== 8'hEF || mem[12'h201] !== 8'hBE || mem[12'h202] !== 8'h11)
            $display("FAIL sh_mem: got %h %h %h required ef be 11", mem[12'h200], mem[12'h201], mem[12'h202]); else n_pass++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
        mem[12'hFFE] = 8'hA1; mem[12'hFFF] = 8'hB2; mem[12'h000] = 8'hC3; mem[12'h001] = 8'hD4;
        drive_op(LW, 32'hFFFFFFFE, 32'h0, 32'h0, 3'd7, 0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            n_checks++; if (t_a[c] !== exp_a[c-1]) $display("FAIL wrap_addr c%0d: got %h required %h", c, t_a[c], exp_a[c-1]); else n_pass++;
        end
        n_checks++; if (t_data[5] !== 32'hD4C3B2A1) $display("FAIL wrap_data: got %h required d4c3b2a1", t_data[5]); else n_pass++;
    endtask

    task automatic test_clear();
        drive_op(LW, 32'h100, 32'h0, 32'd4, 3'd4, 2, 1'b0);
        n_checks++; if (t_rdy[3] !== 1'b1) $display("FAIL clr_rd_ready: got %0b required 1", t_rdy[3]); else n_pass++;
        for (int c = 1; c <= 7; c++) begin
            n_checks++; if (t_des[c] !== 3'd0) $display("FAIL clr_rd_des c%0d: got %0d required 0", c, t_des[c]); else n_pass++;
        end
        for (int i = 0; i < 4; i++) mem[12'h400 + 12'(i)] = 8'h00;
        drive_op(SW, 32'h400, 32'hCAFEF00D, 32'h0, 3'd1, 1, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            n_checks++; if (t_wr[c] !== 1'b1) $display("FAIL clr_wr_wr c%0d: got %0b required 1", c, t_wr[c]); else n_pass++;
        end
        for (int c = 1; c <= 7; c++) begin
            n_checks++; if (t_des[c] !== 3'd0) $display("FAIL clr_wr_des c%0d: got %0d required 0", c, t_des[c]); else n_pass++;
        end
        n_checks++; if ({mem[12'h403], mem[12'h402], mem[12'h401], mem[12'h400]} !== 32'hCAFEF00D)
            $display("FAIL clr_wr_mem: got %h%h%h%h required cafef00d", mem[12'h403], mem[12'h402], mem[12'h401], mem[12'h400]); else n_pass++;
        n_checks++; if (t_rdy[6] !== 1'b1) $display("FAIL clr_wr_ready: got %0b required 1", t_rdy[6]); else n_pass++;
    endtask

    task automatic test_busy_drop();
        mem[12'h500] = 8'h00;
        drive_op(LW, 32'h100, 32'h0, 32'd4, 3'd3, 0, 1'b1);
        n_checks++; if (t_des[5] !== 3'd3) $display("FAIL busy_lw_des: got %0d required 3", t_des[5]); else n_pass++;
        for (int c = 1; c <= 7; c++) begin
            n_checks++; if (t_wr[c] !== 1'b0) $display("FAIL busy_wr c%0d: got %0b required 0", c, t_wr[c]); else n_pass++;
        end
        n_checks++; if (t_des[7] !== 3'd0) $display("FAIL busy_bcast: got %0d required 0", t_des[7]); else n_pass++;
        n_checks++; if (mem[12'h500] !== 8'h00) $display("FAIL busy_mem: got %h required 00", mem[12'h500]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        mem[12'h600] = 8'h00; mem[12'h601] = 8'h00;
        @(negedge clk);
        memory_op = SW; memory_value1 = 32'h600; memory_imm = 0; memory_value2 = 32'h44332211; memory_des = 3'd2;
        @(posedge clk);
        @(negedge clk);
        memory_op = IDLE;
        @(posedge clk);
        if (mem_wr) mem[mem_a[11:0]] = mem_dout;
        @(negedge clk);
        n_checks++; if (mem_wr !== 1'b1) $display("FAIL rmid_wr_before: got %0b required 1", mem_wr); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (mem_wr !== 1'b0) $display("FAIL rmid_wr: got %0b required 0", mem_wr); else n_pass++;
        n_checks++; if (lsu_ready !== 1'b1 || mem_a !== 32'd0 || mem_dout !== 8'd0 || result_des !== 3'd0 || result_data !== 32'd0)
            $display("FAIL rmid_outputs: got rdy=%0b a=%h d=%h des=%0d data=%h required 1 0 0 0 0",
                     lsu_ready, mem_a, mem_dout, result_des, result_data); else n_pass++;
        @(posedge clk);
        if (mem_wr) mem[mem_a[11:0]] = mem_dout;
        @(negedge clk);
        rst = 1'b1;
        n_checks++; if (mem[12'h600] !== 8'h11 || mem[12'h601] !== 8'h00)
            $display("FAIL rmid_mem: got %h %h required 11 00", mem[12'h600], mem[12'h601]); else n_pass++;
    endtask

    task automatic test_random();
        logic [4:0] ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
        for (int it = 0; it < 40; it++) begin
            logic [4:0]  op;
            logic [31:0] v1, v2, imm, addr, expv;
            logic [2:0]  tag;
            int n;
            bit st;
            v1 = $urandom; v2 = $urandom; imm = $urandom; tag = 3'($urandom_range(1, 7));
            addr = v1 + imm;
            if ($urandom_range(0, 5) == 0) begin
                op = 5'($urandom_range(0, 17));
                drive_op(op, v1, v2, imm, tag, 0, 1'b0);
                n_checks++; if (t_rdy[1] !== 1'b1 || t_wr[1] !== 1'b0 || t_des[2] !== 3'd0)
                    $display("FAIL rnd_invalid it%0d: got rdy=%0b wr=%0b des=%0d required 1 0 0", it, t_rdy[1], t_wr[1], t_des[2]); else n_pass++;
            end else begin
                op = ops[$urandom_range(0, 7)];
                n = op_len(op);
                st = op_store(op);
                expv = 0;
                for (int b = 0; b < n; b++) expv = expv + (32'(ref_mem[12'(addr + 32'(b))]) << (8 * b));
                if (op == LB && expv > 127) expv = expv - 256;
                if (op == LH && expv > 32767) expv = expv - 65536;
                if (st) begin
                    expv = 0;
                    for (int b = 0; b < n; b++) ref_mem[12'(addr + 32'(b))] = 8'((v2 >> (8 * b)) & 32'hFF);
                end
                drive_op(op, v1, v2, imm, tag, 0, 1'b0);
                for (int c = 1; c <= n; c++) begin
                    n_checks++; if (t_a[c] !== addr + 32'(c - 1) || t_wr[c] !== st || t_des[c] !== 3'd0 ||
                                    (st && t_dout[c] !== 8'((v2 >> (8 * (c - 1))) & 32'hFF)))
                        $display("FAIL rnd_cycle it%0d c%0d: got a=%h wr=%0b d=%h des=%0d required a=%h wr=%0b", it, c,
                                 t_a[c], t_wr[c], t_dout[c], t_des[c], addr + 32'(c - 1), st); else n_pass++;
                end
                n_checks++; if (t_des[n+1] !== tag || t_data[n+1] !== expv || t_wr[n+1] !== 1'b0)
                    $display("FAIL rnd_result it%0d op=%b: got des=%0d data=%h required des=%0d data=%h", it, op,
                             t_des[n+1], t_data[n+1], tag, expv); else n_pass++;
                n_checks++; if (t_rdy[n+2] !== 1'b1 || t_des[n+2] !== 3'd0)
                    $display("FAIL rnd_idle it%0d: got rdy=%0b des=%0d required 1 0", it, t_rdy[n+2], t_des[n+2]); else n_pass++;
                if (st) begin
                    for (int b = 0; b < n; b++) begin
                        n_checks++; if (mem[12'(addr + 32'(b))] !== ref_mem[12'(addr + 32'(b))])
                            $display("FAIL rnd_mem it%0d b%0d: got %h required %h", it, b,
                                     mem[12'(addr + 32'(b))], ref_mem[12'(addr + 32'(b))]); else n_pass++;
                    end
                end
            end
        end
    endtask

    initial begin
        clear = 1'b0; memory_op = IDLE; memory_value1 = 0; memory_value2 = 0; memory_imm = 0; memory_des = 0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        test_reset();
        test_lw();
        test_sign_ext();
        test_store();
        test_wrap();
        test_clear();
        test_busy_drop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory execution stage directly downstream of the reservation station. Accepts one issued load/store (op, base, store data, immediate, destination tag) and performs it byte-serially over a byte-wide memory port. Broadcasts the completed result and tag for one cycle on the memory result bus, which the reservation station and ROB snoop. Non-pipelined: one access in flight.

Parameters:
ADDR_WIDTH, 32, width of the byte address driven on mem_a; effective address is truncated to the low ADDR_WIDTH bits.
IDLE_OP, 5'b11111, op encoding meaning "no instruction".

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  asynchronous, active-low reset
clear  in  1  synchronous flush (branch mispredict)
memory_op  in  5  issued op; IDLE_OP = none
memory_value1  in  32  base register value
memory_value2  in  32  store data
memory_imm  in  32  address offset
memory_des  in  3  destination tag; 0 = no tag
lsu_ready  out  1  registered; 1 = op on inputs will be accepted at next posedge
mem_a  out  ADDR_WIDTH  byte address
mem_dout  out  8  write byte
mem_wr  out  1  1 = write mem_dout to mem_a this cycle
mem_din  in  8  read byte; valid one cycle after mem_a presented with mem_wr=0
result_data  out  32  broadcast value (memory_data on RS side)
result_des  out  3  broadcast tag (memory_des_in on RS side); 0 = no broadcast

Behaviour:
- Reset (rst=0, async): state IDLE, lsu_ready=1, mem_a=0, mem_dout=0, mem_wr=0, result_data=0, result_des=0, internal counters/tag/data cleared.
- Ops: LB 10010, LH 10011, LW 10100, LBU 10101, LHU 10110, SB 10111, SH 11000, SW 11001. Byte count N = 1/2/4. Any other non-IDLE_OP code: ignored, no state change, no broadcast.
- Accept: posedge with state IDLE, lsu_ready=1, clear=0, valid memory op. Latches op, tag, store data; addr = (value1 + imm) mod 2^32, truncated to ADDR_WIDTH. lsu_ready<=0. Op presented while not ready is dropped; upstream must hold or re-present.
- States: IDLE, READ, WRITE, DONE.
- READ (edge E0 = accept): E0 drives mem_a=addr, mem_wr=0. At edge Ek (k=1..N) sample mem_din as byte k-1 and drive mem_a=addr+k while k<N. At E_N go DONE: result_data = assembled little-endian value; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; result_des = tag.
- WRITE: E0 drives mem_a=addr, mem_dout=byte0 (value2[7:0]), mem_wr=1. At Ek (k=1..N-1) drive byte k at addr+k. At E_N: mem_wr=0, go DONE, result_data=0, result_des=tag.
- Latency: accept edge to result visible = N cycles for loads and stores (LW/SW 4, LB/SB 1).
- DONE: broadcast is exactly one cycle. Next edge: result_des=0, result_data=0, state IDLE, lsu_ready=1. No accept during DONE.
- Address increment wraps modulo 2^ADDR_WIDTH. Misaligned accesses permitted (byte-serial, no alignment check).
- clear in IDLE: current op not accepted. clear in READ: abandon next edge, go IDLE, lsu_ready=1, no broadcast. clear in WRITE: remaining bytes are still written (no torn stores); DONE broadcast suppressed (result_des stays 0). clear in DONE: broadcast cycle already visible completes; return to IDLE.
- Reset mid-operation: immediate return to reset values; mem_wr drops asynchronously; partial store bytes remain in memory.
- Tag 0 on accept: access performed, broadcast cycle carries result_des=0, i.e. invisible.

Test Plan:
- LW, value1=0x100, imm=4, mem[0x104..0x107]=78 56 34 12 -> mem_a 0x104..0x107 on consecutive cycles, result_data=0x12345678, result_des=tag 4 cycles after accept for exactly 1 cycle, lsu_ready high the cycle after.
- LB vs LBU at byte 0x80 -> 0xFFFFFF80 vs 0x00000080; LH at 0x00 0x80 -> 0xFFFF8000; each N cycles.
- SH, value2=0xDEADBEEF, addr=0x200 -> mem_wr=1 two cycles writing EF@0x200, BE@0x201, then result_des=tag, result_data=0.
- Wrap: LW value1=0xFFFFFFFE, imm=0 -> mem_a FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- clear on cycle 2 of LW -> no broadcast, lsu_ready=1 next cycle; clear on cycle 1 of SW -> all 4 bytes written, result_des stays 0.
- Op presented while lsu_ready=0 -> ignored; rst low mid-SW -> mem_wr=0 immediately, all outputs at reset values.
